// File: rtl/digital_clk_pkg.sv
// Shared constants and helpers for the time-of-day clock.
// Field limits/widths and the 24h -> 12h display mapping.
package digital_clk_pkg;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int SEC_W    = 6;
    localparam int MIN_W    = 6;
    localparam int HOUR_W   = 5;

    // Returns {pm, hour12}: 0 -> 12 AM, 13..23 -> 1..11 PM.
    function automatic logic [HOUR_W:0] to_12h(
        input logic [HOUR_W-1:0] hour
    );
        logic              pm;
        logic [HOUR_W-1:0] h12;
        pm = (hour >= 5'd12);
        if (hour == '0)
            h12 = 5'd12;
        else if (hour > 5'd12)
            h12 = hour - 5'd12;
        else
            h12 = hour;
        return {pm, h12};
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with synchronous load, used for each time field.
// Ports: clk_i, reset_i (sync, active high), inc_i, load_i, load_val_i,
//   q_o (count), wrap_o (inc_i while at MAX; carry into next field).
module mod_counter
    import digital_clk_pkg::*;
#(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         inc_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] q_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_ff @(posedge clk_i) begin
        if (reset_i)
            q_o <= '0;
        else if (load_i)
            q_o <= load_val_i;
        else if (inc_i)
            q_o <= (q_o == MAX_V) ? '0 : q_o + 1'b1;
    end

    // Combinational so the whole carry chain settles in one cycle.
    assign wrap_o = inc_i & (q_o == MAX_V);

endmodule

// File: rtl/digital_clk_param.sv
// Parametrised time-of-day clock: prescaler, ms/sec/min/hour chain,
// time-set load, 12/24h display and a one-cycle second strobe.
// Ports: clk_i, reset_i (sync, active high); Timeset/Hourset/Minset/
//   Secset load the time; mode12_i selects 12h display; outputs
//   ms_o, sec_o, min_o, hour_o, pm_o, sec_tick_o.
// Macro ALARM_CLK_EN adds the alarm (alarm_set_i, alarm_hour_i,
//   alarm_min_i, alarm_arm_i, alarm_ack_i, alarm_o).
module digital_clk_param
    import digital_clk_pkg::*;
#(
    parameter int CLK_PER_MS = 1,
    parameter int MS_PER_SEC = 1000,
    parameter int MS_W       = 10
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              Timeset,
    input  logic [HOUR_W-1:0] Hourset,
    input  logic [MIN_W-1:0]  Minset,
    input  logic [SEC_W-1:0]  Secset,
    input  logic              mode12_i,
`ifdef ALARM_CLK_EN
    input  logic              alarm_set_i,
    input  logic [HOUR_W-1:0] alarm_hour_i,
    input  logic [MIN_W-1:0]  alarm_min_i,
    input  logic              alarm_arm_i,
    input  logic              alarm_ack_i,
    output logic              alarm_o,
`endif
    output logic [MS_W-1:0]   ms_o,
    output logic [SEC_W-1:0]  sec_o,
    output logic [MIN_W-1:0]  min_o,
    output logic [HOUR_W-1:0] hour_o,
    output logic              pm_o,
    output logic              sec_tick_o
);

    localparam int PRE_W =
        (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX =
        PRE_W'(CLK_PER_MS - 1);

    logic [PRE_W-1:0]  pre;
    logic              ms_tick;
    logic              ms_wrap;
    logic              sec_wrap;
    logic              min_wrap;
    logic              day_wrap_unused;
    logic [HOUR_W-1:0] hour;
    logic [HOUR_W-1:0] hour_ld;
    logic [MIN_W-1:0]  min_ld;
    logic [SEC_W-1:0]  sec_ld;
    logic [HOUR_W:0]   disp12;

    // Out-of-range set fields load zero independently.
    assign hour_ld = (Hourset > HOUR_W'(HOUR_MAX)) ? '0 : Hourset;
    assign min_ld  = (Minset > MIN_W'(MIN_MAX)) ? '0 : Minset;
    assign sec_ld  = (Secset > SEC_W'(SEC_MAX)) ? '0 : Secset;

    // Prescaler restarts on load so the first ms step lands
    // exactly CLK_PER_MS cycles after Timeset falls.
    always_ff @(posedge clk_i) begin
        if (reset_i || Timeset)
            pre <= '0;
        else if (pre == PRE_MAX)
            pre <= '0;
        else
            pre <= pre + 1'b1;
    end

    assign ms_tick = ~Timeset & (pre == PRE_MAX);

    mod_counter #(.W(MS_W), .MAX(MS_PER_SEC - 1)) u_ms (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .inc_i      (ms_tick),
        .load_i     (Timeset),
        .load_val_i ('0),
        .q_o        (ms_o),
        .wrap_o     (ms_wrap)
    );

    mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .inc_i      (ms_wrap),
        .load_i     (Timeset),
        .load_val_i (sec_ld),
        .q_o        (sec_o),
        .wrap_o     (sec_wrap)
    );

    mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .inc_i      (sec_wrap),
        .load_i     (Timeset),
        .load_val_i (min_ld),
        .q_o        (min_o),
        .wrap_o     (min_wrap)
    );

    mod_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .inc_i      (min_wrap),
        .load_i     (Timeset),
        .load_val_i (hour_ld),
        .q_o        (hour),
        .wrap_o     (day_wrap_unused)
    );

    // Registered alongside the sec counter, so the strobe and
    // the new second value appear on the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i || Timeset)
            sec_tick_o <= 1'b0;
        else
            sec_tick_o <= ms_wrap;
    end

    assign disp12 = to_12h(hour);
    assign hour_o = mode12_i ? disp12[HOUR_W-1:0] : hour;
    assign pm_o   = disp12[HOUR_W];

`ifdef ALARM_CLK_EN
    logic [HOUR_W-1:0] al_hour;
    logic [MIN_W-1:0]  al_min;
    logic [HOUR_W-1:0] next_hour;
    logic [MIN_W-1:0]  next_min;
    logic              alarm_hit;

    // sec_wrap means the next state is hh:mm:00.000; compare
    // against the hh:mm being rolled into.
    assign next_min = min_wrap ? '0 :
                      sec_wrap ? min_o + 1'b1 : min_o;
    assign next_hour =
        !min_wrap                      ? hour :
        (hour == HOUR_W'(HOUR_MAX))    ? '0   :
                                         hour + 1'b1;
    assign alarm_hit = alarm_arm_i & sec_wrap &
                       (next_hour == al_hour) &
                       (next_min == al_min);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            al_hour <= '0;
            al_min  <= '0;
            alarm_o <= 1'b0;
        end else begin
            if (alarm_set_i) begin
                al_hour <= (alarm_hour_i > HOUR_W'(HOUR_MAX)) ?
                           '0 : alarm_hour_i;
                al_min  <= (alarm_min_i > MIN_W'(MIN_MAX)) ?
                           '0 : alarm_min_i;
            end
            // A new match wins over a coincident acknowledge.
            if (alarm_hit)
                alarm_o <= 1'b1;
            else if (alarm_ack_i)
                alarm_o <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_digital_clk_param.sv
// Bench for digital_clk_param: two instances (1 clk/ms x 1000 ms/s,
// 4 clk/ms x 10 ms/s) against a milliseconds-of-day model.
module tb_digital_clk_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       timeset = 1'b0;
    logic [4:0] hset = '0;
    logic [5:0] mset = '0;
    logic [5:0] sset = '0;
    logic       mode12 = 1'b0;
    logic       alarm_set = 1'b0;
    logic [4:0] ahr = '0;
    logic [5:0] amin = '0;
    logic       arm = 1'b0;
    logic       ack = 1'b0;

    logic [9:0] ms0;
    logic [5:0] sec0, min0;
    logic [4:0] hr0;
    logic       pm0, tk0, al0;
    logic [3:0] ms1;
    logic [5:0] sec1, min1;
    logic [4:0] hr1;
    logic       pm1, tk1, al1;

    int n_vec = 0;
    int n_err = 0;
    int ticks0 = 0;

    longint t[2];
    int     pre[2];
    int     tk_m[2];
    int     al_m[2];
    int     alh[2];
    int     alm[2];
    int     cpm[2] = '{1, 4};
    longint mps[2] = '{1000, 10};

    always #5 clk = ~clk;

`ifndef ALARM_CLK_EN
    assign al0 = 1'b0;
    assign al1 = 1'b0;
`endif

    digital_clk_param #(
        .CLK_PER_MS(1), .MS_PER_SEC(1000), .MS_W(10)
    ) dut0 (
        .clk_i(clk), .reset_i(reset), .Timeset(timeset),
        .Hourset(hset), .Minset(mset), .Secset(sset),
        .mode12_i(mode12),
`ifdef ALARM_CLK_EN
        .alarm_set_i(alarm_set), .alarm_hour_i(ahr),
        .alarm_min_i(amin), .alarm_arm_i(arm),
        .alarm_ack_i(ack), .alarm_o(al0),
`endif
        .ms_o(ms0), .sec_o(sec0), .min_o(min0),
        .hour_o(hr0), .pm_o(pm0), .sec_tick_o(tk0)
    );

    digital_clk_param #(
        .CLK_PER_MS(4), .MS_PER_SEC(10), .MS_W(4)
    ) dut1 (
        .clk_i(clk), .reset_i(reset), .Timeset(timeset),
        .Hourset(hset), .Minset(mset), .Secset(sset),
        .mode12_i(mode12),
`ifdef ALARM_CLK_EN
        .alarm_set_i(alarm_set), .alarm_hour_i(ahr),
        .alarm_min_i(amin), .alarm_arm_i(arm),
        .alarm_ack_i(ack), .alarm_o(al1),
`endif
        .ms_o(ms1), .sec_o(sec1), .min_o(min1),
        .hour_o(hr1), .pm_o(pm1), .sec_tick_o(tk1)
    );

    task automatic chk(input string tag, input int got,
                       input int exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, got, exp);
        end
    endtask

    // Time is kept as milliseconds since midnight.
    task automatic model_update();
        longint mp;
        int     h, m, s;
        bit     hit;
        for (int k = 0; k < 2; k++) begin
            mp  = mps[k];
            hit = 1'b0;
            if (reset) begin
                t[k] = 0; pre[k] = 0; tk_m[k] = 0;
                al_m[k] = 0; alh[k] = 0; alm[k] = 0;
            end else begin
                if (timeset) begin
                    h = (hset > 23) ? 0 : int'(hset);
                    m = (mset > 59) ? 0 : int'(mset);
                    s = (sset > 59) ? 0 : int'(sset);
                    t[k] = longint'((h * 60 + m) * 60 + s) * mp;
                    pre[k] = 0;
                    tk_m[k] = 0;
                end else if (pre[k] == cpm[k] - 1) begin
                    pre[k] = 0;
                    t[k] = (t[k] + 1) % (86400 * mp);
                    tk_m[k] = (t[k] % mp == 0) ? 1 : 0;
                    hit = arm && (t[k] % (60 * mp) == 0) &&
                          (t[k] / (3600 * mp) == alh[k]) &&
                          ((t[k] / (60 * mp)) % 60 == alm[k]);
                end else begin
                    pre[k]++;
                    tk_m[k] = 0;
                end
                if (hit) al_m[k] = 1;
                else if (ack) al_m[k] = 0;
                if (alarm_set) begin
                    alh[k] = (ahr > 23) ? 0 : int'(ahr);
                    alm[k] = (amin > 59) ? 0 : int'(amin);
                end
            end
        end
    endtask

    task automatic check_dut(input int k, input int ms,
                             input int sec, input int mn,
                             input int hr, input int pm,
                             input int tk, input int al);
        longint mp;
        int     h, eh;
        mp = mps[k];
        h  = int'(t[k] / (3600 * mp));
        eh = !mode12 ? h : (h == 0) ? 12 : (h > 12) ? h - 12 : h;
        chk($sformatf("d%0d_ms", k), ms, int'(t[k] % mp));
        chk($sformatf("d%0d_sec", k), sec,
            int'((t[k] / mp) % 60));
        chk($sformatf("d%0d_min", k), mn,
            int'((t[k] / (60 * mp)) % 60));
        chk($sformatf("d%0d_hour", k), hr, eh);
        chk($sformatf("d%0d_pm", k), pm, (h >= 12) ? 1 : 0);
        chk($sformatf("d%0d_tick", k), tk, tk_m[k]);
`ifdef ALARM_CLK_EN
        chk($sformatf("d%0d_alarm", k), al, al_m[k]);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        ticks0 += int'(tk0);
        check_dut(0, ms0, sec0, min0, hr0, pm0, tk0, al0);
        check_dut(1, ms1, sec1, min1, hr1, pm1, tk1, al1);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic load(input int h, input int m, input int s);
        timeset = 1'b1;
        hset = 5'(h); mset = 6'(m); sset = 6'(s);
        step();
        timeset = 1'b0;
    endtask

    initial begin
        // Reset held, then released
        run(5);
        chk("rst_ms", ms0, 0);
        chk("rst_hour", hr0, 0);
        chk("rst_tick", tk0, 0);
        reset = 1'b0;
        step();
        chk("rel_ms", ms0, 1);

        // 11:59:59 -> noon
        load(11, 59, 59);
        ticks0 = 0;
        run(1000);
        chk("noon_hour", hr0, 12);
        chk("noon_ms", ms0, 0);
        chk("noon_sec", sec0, 0);
        chk("noon_pm", pm0, 1);
        chk("noon_ticks", ticks0, 1);
        mode12 = 1'b1;
        step();
        chk("noon_h12", hr0, 12);
        load(13, 0, 0);
        chk("h13_h12", hr0, 1);
        chk("h13_pm", pm0, 1);

        // Midnight rollover
        mode12 = 1'b0;
        load(23, 59, 59);
        run(1000);
        chk("mid_hour", hr0, 0);
        chk("mid_min", min0, 0);
        chk("mid_ms", ms0, 0);
        chk("mid_pm", pm0, 0);
        mode12 = 1'b1;
        step();
        chk("mid_h12", hr0, 12);
        mode12 = 1'b0;

        // Out-of-range set values, held while Timeset high
        timeset = 1'b1;
        hset = 5'd25; mset = 6'd60; sset = 6'd30;
        run(4);
        chk("oor_hour", hr0, 0);
        chk("oor_min", min0, 0);
        chk("oor_sec", sec0, 30);
        chk("oor_ms", ms0, 0);

        // Prescaled instance: one ms every 4th cycle
        timeset = 1'b0;
        run(3);
        chk("pre_ms_3", ms1, 0);
        step();
        chk("pre_ms_4", ms1, 1);
        run(4);
        chk("pre_ms_8", ms1, 2);
        run(2);
        reset = 1'b1;
        timeset = 1'b1;
        step();
        chk("rst_mid_ms", ms1, 0);
        chk("rst_mid_sec", sec1, 0);
        reset = 1'b0;
        timeset = 1'b0;
        run(3);

`ifdef ALARM_CLK_EN
        alarm_set = 1'b1; ahr = 5'd12; amin = 6'd0; arm = 1'b1;
        step();
        alarm_set = 1'b0;
        load(11, 59, 59);
        run(999);
        chk("al_before", al0, 0);
        step();
        chk("al_match", al0, 1);
        run(5);
        chk("al_sticky", al0, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("al_ack", al0, 0);
        load(11, 59, 59);
        ack = 1'b1;
        run(1000);
        chk("al_coinc", al0, 1);
        step();
        chk("al_coinc_clr", al0, 0);
        ack = 1'b0;
        arm = 1'b0;
        load(11, 59, 59);
        run(1000);
        chk("al_disarm", al0, 0);
`endif

        // Random loads, resets, display mode and alarm traffic
        for (int seg = 0; seg < 25; seg++) begin
            int kind, len;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                reset = 1'b1;
                run($urandom_range(1, 2));
                reset = 1'b0;
            end else if (kind < 5) begin
                timeset = 1'b1;
                hset = 5'($urandom_range(0, 31));
                mset = 6'($urandom_range(0, 63));
                sset = 6'($urandom_range(0, 63));
                run($urandom_range(1, 3));
                timeset = 1'b0;
            end else begin
                load(23 - $urandom_range(0, 12), 59, 59);
            end
            alarm_set = 1'b1;
            ahr = 5'($urandom_range(0, 24));
            amin = 6'($urandom_range(0, 1) ? 0 : 60);
            arm = 1'($urandom_range(0, 1));
            step();
            alarm_set = 1'b0;
            len = $urandom_range(1, 2000);
            for (int i = 0; i < len; i++) begin
                mode12 = 1'($urandom_range(0, 1));
                ack = ($urandom_range(0, 99) == 0);
                step();
            end
            ack = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
